// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to unsigned-binary converter (reverse double dabble), one conversion in flight.
// Optional invalid-digit detection is compiled in with `define BCD_CHECK_EN.
`timescale 1ns/1ps

module bcd_to_bin_seq #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    function automatic bit width_ok(input int d, input int w);
        longint unsigned p10;
        p10 = 1;
        for (int i = 0; i < d; i++) p10 = p10 * 10;
        if (w >= 64) return 1'b1;
        return (64'(1) << w) >= p10;
    endfunction

    generate
        if (!width_ok(DIGITS, BIN_W)) begin : g_width_check
            $error("bcd_to_bin_seq: BIN_W too small to hold 10**DIGITS - 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [BCD_W-1:0]   bcd_sh_q, bcd_sh_d;
    logic [BIN_W-1:0]   bin_sh_q, bin_sh_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   bin_out_q, bin_out_d;

    logic                     accept;
    logic                     last_shift;
    logic [BCD_W+BIN_W-1:0]   shifted;
    logic [BCD_W-1:0]         bcd_fixed;

    // Each nibble is corrected on its own; there is never a borrow between digits.
    function automatic logic [BCD_W-1:0] correct(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd8) r[4*i +: 4] = v[4*i +: 4] - 4'd3;
        end
        return r;
    endfunction

    assign accept     = in_valid && in_ready;
    assign last_shift = (cnt_q == CNT_W'(BIN_W - 1));
    assign shifted    = {bcd_sh_q, bin_sh_q} >> 1;
    assign bcd_fixed  = correct(shifted[BIN_W +: BCD_W]);

`ifdef BCD_CHECK_EN
    logic err_q, err_d;
    logic bad_digit;

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bcd_sh_q  <= '0;
            bin_sh_q  <= '0;
            cnt_q     <= '0;
            bin_out_q <= '0;
`ifdef BCD_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bcd_sh_q  <= bcd_sh_d;
            bin_sh_q  <= bin_sh_d;
            cnt_q     <= cnt_d;
            bin_out_q <= bin_out_d;
`ifdef BCD_CHECK_EN
            err_q     <= err_d;
`endif
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef BCD_CHECK_EN
                    state_d = bad_digit ? DONE : SHIFT;
`else
                    state_d = SHIFT;
`endif
                end
            end
            SHIFT:   if (last_shift) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bcd_sh_d  = bcd_sh_q;
        bin_sh_d  = bin_sh_q;
        cnt_d     = cnt_q;
        bin_out_d = bin_out_q;
`ifdef BCD_CHECK_EN
        err_d     = err_q;
`endif
        if (state_q == IDLE && accept) begin
            bcd_sh_d = bcd_in;
            bin_sh_d = '0;
            cnt_d    = '0;
`ifdef BCD_CHECK_EN
            err_d    = bad_digit;
            if (bad_digit) bin_out_d = '0;
`endif
        end else if (state_q == SHIFT) begin
            bcd_sh_d = bcd_fixed;
            bin_sh_d = shifted[BIN_W-1:0];
            cnt_d    = cnt_q + CNT_W'(1);
            if (last_shift) bin_out_d = shifted[BIN_W-1:0];
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    assign bin_out = bin_out_q;

endmodule
